// File: rtl/arch_defs_pkg.sv
// Shared architecture constants and the RAM port arbiter state encoding.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_ACK,
    LDR_ACC,
    LDR_ACK
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between the CPU and the debug/program loader.
// Each access runs arbitrate -> access -> acknowledge.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | arbitrate; lock and starvation decide the winner
// CPU_ACC | CPU we/addr/wdata on the RAM port, RAM samples at cycle end
// CPU_ACK | cpu_ack pulse, cpu_rdata carries ram_rdata
// LDR_ACC | loader we/addr/wdata on the RAM port
// LDR_ACK | ldr_ack pulse, ldr_rdata carries ram_rdata
module ram_port_arbiter #(
  parameter int DATA_WIDTH   = arch_defs_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = arch_defs_pkg::ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_ack,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  input  logic                  ldr_lock,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  import arch_defs_pkg::*;

  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  arb_state_t     state, next_state;
  logic [SCW-1:0] starve_cnt;
  logic           lock_held;
  logic           starve_hit;
  logic           cpu_grant, ldr_grant;

  assign starve_hit = (starve_cnt == SCW'(STARVE_LIMIT));
  assign cpu_stall  = cpu_req & (state != CPU_ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Loader wins while it holds the lock, when the CPU is absent, or once starved.
  always_comb begin
    next_state = state;
    cpu_grant  = 1'b0;
    ldr_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (ldr_req && (lock_held || !cpu_req || starve_hit)) begin
          ldr_grant  = 1'b1;
          next_state = LDR_ACC;
        end else if (cpu_req && !lock_held) begin
          cpu_grant  = 1'b1;
          next_state = CPU_ACC;
        end
      end
      CPU_ACC: next_state = CPU_ACK;
      CPU_ACK: next_state = IDLE;
      LDR_ACC: next_state = LDR_ACK;
      LDR_ACK: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    ldr_ack   = 1'b0;
    ldr_rdata = '0;
    case (state)
      CPU_ACC: begin
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      LDR_ACC: begin
        ram_we    = ldr_we;
        ram_addr  = ldr_addr;
        ram_wdata = ldr_wdata;
      end
      CPU_ACK: begin
        cpu_ack   = 1'b1;
        cpu_rdata = ram_rdata;
      end
      LDR_ACK: begin
        ldr_ack   = 1'b1;
        ldr_rdata = ram_rdata;
      end
      default: ;
    endcase
  end

  // Lock is taken on a locked loader grant and dropped in IDLE once ldr_lock falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      lock_held  <= 1'b0;
    end else if (state == IDLE) begin
      if (ldr_grant)
        starve_cnt <= '0;
      else if (cpu_grant && ldr_req && !starve_hit)
        starve_cnt <= starve_cnt + SCW'(1);

      if (ldr_grant && ldr_lock)
        lock_held <= 1'b1;
      else if (!ldr_lock)
        lock_held <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural synchronous RAM.
module tb_ram_port_arbiter;
  import arch_defs_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ldr_req, ldr_we, ldr_ack, ldr_lock;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_lock(ldr_lock),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic          chk;
    logic [DW-1:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t ldr_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cpu_ack_cnt = 0;
  bit   watch_stall = 1'b0;
  bit   done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic chk, input int lat);
    exp_t e;
    int   n;
    bit   got;
    e.chk = chk & ~we;
    e.data = d;
    cpu_q.push_back(e);
    cpu_we = we; cpu_addr = a; cpu_wdata = we ? d : '0; cpu_req = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        check("cpu_stall_ack", {31'b0, cpu_stall}, 32'd0);
        got = 1'b1;
        break;
      end
      check("cpu_stall_wait", {31'b0, cpu_stall}, 32'd1);
      n++;
    end
    if (!got) fail_now("cpu_ack_timeout");
    else if (lat >= 0) check("cpu_latency", n, lat);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic ldr_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic chk, input int lat);
    exp_t e;
    int   n;
    bit   got;
    e.chk = chk & ~we;
    e.data = d;
    ldr_q.push_back(e);
    ldr_we = we; ldr_addr = a; ldr_wdata = we ? d : '0; ldr_req = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ldr_ack) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    if (!got) fail_now("ldr_ack_timeout");
    else if (lat >= 0) check("ldr_latency", n, lat);
    tick();
    ldr_req = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (cpu_ack) begin
        cpu_ack_cnt++;
        if (cpu_q.size() == 0) fail_now("cpu_ack_unexpected");
        else begin
          e = cpu_q.pop_front();
          if (e.chk) check("cpu_rdata", cpu_rdata, e.data);
        end
      end else check("cpu_rdata_idle", cpu_rdata, 0);
      if (ldr_ack) begin
        if (ldr_q.size() == 0) fail_now("ldr_ack_unexpected");
        else begin
          e = ldr_q.pop_front();
          if (e.chk) check("ldr_rdata", ldr_rdata, e.data);
        end
      end else check("ldr_rdata_idle", ldr_rdata, 0);
      if (watch_stall) check("cpu_stall_locked", {31'b0, cpu_stall}, 32'd1);
    end
  endtask

  task automatic stimulus();
    int c0;
    int grants[$];
    exp_t e;

    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
    repeat (2) @(negedge clk);
    check("rst_ram_we", {31'b0, ram_we}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_cpu_ack", {31'b0, cpu_ack}, 0);
    check("rst_ldr_ack", {31'b0, ldr_ack}, 0);
    check("rst_cpu_stall_lo", {31'b0, cpu_stall}, 0);
    cpu_req = 1'b1;
    #1 check("rst_cpu_stall_hi", {31'b0, cpu_stall}, 1);
    cpu_req = 1'b0;
    @(posedge clk); #3 reset = 1'b1;
    tick();

    // preload through unlocked loader writes
    ldr_access(1'b1, 4'h3, 8'h33, 1'b0, 2);
    ldr_access(1'b1, 4'h5, 8'h42, 1'b0, 2);
    ldr_access(1'b1, 4'h1, 8'h11, 1'b0, 2);
    ldr_access(1'b1, 4'h2, 8'h22, 1'b0, 2);
    ldr_access(1'b1, 4'hA, 8'h5A, 1'b0, 2);

    // reset during CPU_ACC of a write: the write must not land
    cpu_we = 1'b1; cpu_addr = 4'h3; cpu_wdata = 8'hAA; cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("acc_ram_we", {31'b0, ram_we}, 1);
    check("acc_ram_addr", ram_addr, 32'h3);
    #2 reset = 1'b0;
    #1;
    check("rstmid_ram_we", {31'b0, ram_we}, 0);
    check("rstmid_ram_addr", ram_addr, 0);
    check("rstmid_state", 32'(dut.state), 32'(IDLE));
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("rstmid_mem3", mem[3], 32'h33);
    #3 reset = 1'b1;
    tick();
    check("rel_state", 32'(dut.state), 32'(IDLE));
    check("rel_mem3", mem[3], 32'h33);

    // re-request, then reads
    cpu_access(1'b1, 4'h3, 8'hAA, 1'b0, 2);
    cpu_access(1'b0, 4'h3, 8'hAA, 1'b1, 2);
    cpu_access(1'b0, 4'h5, 8'h42, 1'b1, 2);

    // contention: CPU first, loader acks 3 cycles later
    fork
      cpu_access(1'b0, 4'h1, 8'h11, 1'b1, 2);
      ldr_access(1'b0, 4'h2, 8'h22, 1'b1, 5);
    join

    // starvation: both held, expect C C C C L
    e.chk = 1'b1; e.data = 8'h11;
    repeat (4) cpu_q.push_back(e);
    e.data = 8'h22;
    ldr_q.push_back(e);
    cpu_we = 0; cpu_addr = 4'h1; cpu_req = 1'b1;
    ldr_we = 0; ldr_addr = 4'h2; ldr_wdata = '0; ldr_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_ack) grants.push_back(0);
      if (ldr_ack) grants.push_back(1);
      if (ldr_ack || grants.size() >= 5) break;
    end
    tick();
    cpu_req = 1'b0; ldr_req = 1'b0;
    check("starve_grant_count", grants.size(), 5);
    for (int i = 0; i < grants.size() && i < 5; i++)
      check($sformatf("starve_grant_%0d", i), grants[i], (i == 4) ? 1 : 0);
    @(negedge clk);
    check("starve_cnt_cleared", 32'(dut.starve_cnt), 0);
    tick();

    // locked burst with the CPU waiting
    ldr_lock = 1'b1;
    ldr_access(1'b1, 4'h0, 8'h01, 1'b0, 2);
    c0 = cpu_ack_cnt;
    fork
      cpu_access(1'b0, 4'hA, 8'h5A, 1'b1, -1);
      begin
        watch_stall = 1'b1;
        for (int i = 1; i < 8; i++) ldr_access(1'b1, AW'(i), DW'(i + 1), 1'b0, 2);
        check("lock_no_cpu_ack", cpu_ack_cnt, c0);
        watch_stall = 1'b0;
        ldr_lock = 1'b0;
      end
    join
    for (int i = 0; i < 8; i++) check($sformatf("image_mem%0d", i), mem[i], i + 1);

    // loader places a value, CPU reads it back after unlock
    ldr_lock = 1'b1;
    ldr_access(1'b1, 4'h9, 8'hE0, 1'b0, 2);
    ldr_lock = 1'b0;
    cpu_access(1'b0, 4'h9, 8'hE0, 1'b1, -1);

    repeat (3) tick();
    check("cpu_q_drained", cpu_q.size(), 0);
    check("ldr_q_drained", ldr_q.size(), 0);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
